// File: rtl/rotary_pos_tracker_pkg.sv
// Shared constants for the rotary position tracker: quadrature transition codes,
// detent sub-count sizing and default bus/step values.
package rotary_pos_tracker_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_STEP  = 4;

   // Signed sub-count holds -3..+3; a detent completes on reaching +/-DETENT.
   localparam int unsigned SUB_W  = 3;
   localparam int          DETENT = 4;

   // Transition codes are {previous AB, current AB}.
   localparam logic [3:0] FWD_00_01 = 4'b00_01;
   localparam logic [3:0] FWD_01_11 = 4'b01_11;
   localparam logic [3:0] FWD_11_10 = 4'b11_10;
   localparam logic [3:0] FWD_10_00 = 4'b10_00;
   localparam logic [3:0] REV_00_10 = 4'b00_10;
   localparam logic [3:0] REV_10_11 = 4'b10_11;
   localparam logic [3:0] REV_11_01 = 4'b11_01;
   localparam logic [3:0] REV_01_00 = 4'b01_00;

   typedef enum logic [1:0] {
      MvNone,
      MvInc,
      MvDec
   } move_e;

endpackage

// File: rtl/rotary_pos_tracker_quad_axis.sv
// One encoder axis: synchronise and debounce A/B, decode quadrature, accumulate
// detents and keep a saturating position register.
module quad_axis
   import rotary_pos_tracker_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned STEP       = DEF_STEP,
   parameter int unsigned MIN        = 0,
   parameter int unsigned MAX        = 620
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] reset_value,
   input  logic             a,
   input  logic             b,
   output logic [WIDTH-1:0] pos,
   output logic             chg,
   output logic             err
);

   localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [SUB_W:0]   DET_POS  = (SUB_W+1)'(DETENT);
   localparam logic [SUB_W:0]   DET_NEG  = (SUB_W+1)'(-DETENT);
   localparam logic [WIDTH:0]   MIN_W    = (WIDTH+1)'(MIN);
   localparam logic [WIDTH:0]   MAX_W    = (WIDTH+1)'(MAX);
   localparam logic [WIDTH:0]   STEP_W   = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   MIN_STEP = (WIDTH+1)'(MIN + STEP);

   logic [1:0]             sync1_q, sync2_q;
   logic [1:0]             deb_q, deb_d, prev_q;
   logic [DEB_W-1:0]       cnt_q [2];
   logic [DEB_W-1:0]       cnt_d [2];
   logic signed [1:0]      dir;
   logic                   illegal;
   logic signed [SUB_W:0]  sub_sum;
   logic signed [SUB_W-1:0] sub_q, sub_d;
   move_e                  req_q, req_d;
   logic                   err_q;
   logic [WIDTH-1:0]       pos_q, pos_d, rst_pos;
   logic [WIDTH:0]         pos_ext, rv_ext;
   logic                   chg_q;

   // Counter only advances while the synced level disagrees with the accepted one.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DEB_LAST) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      dir     = '0;
      illegal = 1'b0;
      case ({prev_q, deb_q})
         FWD_00_01, FWD_01_11, FWD_11_10, FWD_10_00: dir = 2'sd1;
         REV_00_10, REV_10_11, REV_11_01, REV_01_00: dir = -2'sd1;
         default: illegal = ((prev_q ^ deb_q) == 2'b11);
      endcase
      sub_sum = $signed({sub_q[SUB_W-1], sub_q}) + $signed({{(SUB_W-1){dir[1]}}, dir});
      req_d   = MvNone;
      if (sub_sum == DET_POS) begin
         req_d = MvInc;
         sub_d = '0;
      end else if (sub_sum == DET_NEG) begin
         req_d = MvDec;
         sub_d = '0;
      end else begin
         sub_d = sub_sum[SUB_W-1:0];
      end
   end

   // Compare in WIDTH+1 bits so neither bound check can wrap.
   always_comb begin
      pos_d   = pos_q;
      pos_ext = {1'b0, pos_q};
      rv_ext  = {1'b0, reset_value};
      unique case (req_q)
         MvInc: pos_d = (pos_ext + STEP_W > MAX_W) ? MAX_W[WIDTH-1:0]
                                                   : pos_q + STEP_W[WIDTH-1:0];
         MvDec: pos_d = (pos_ext < MIN_STEP) ? MIN_W[WIDTH-1:0]
                                             : pos_q - STEP_W[WIDTH-1:0];
         default: pos_d = pos_q;
      endcase
      if (rv_ext < MIN_W) begin
         rst_pos = MIN_W[WIDTH-1:0];
      end else if (rv_ext > MAX_W) begin
         rst_pos = MAX_W[WIDTH-1:0];
      end else begin
         rst_pos = reset_value;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         cnt_q   <= '{default: '0};
         prev_q  <= '0;
         sub_q   <= '0;
         req_q   <= MvNone;
         err_q   <= 1'b0;
         pos_q   <= rst_pos;
         chg_q   <= 1'b0;
      end else begin
         sync1_q <= {a, b};
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         prev_q  <= deb_q;
         sub_q   <= sub_d;
         req_q   <= req_d;
         err_q   <= illegal;
         pos_q   <= pos_d;
         chg_q   <= (pos_d != pos_q);
      end
   end

   assign pos = pos_q;
   assign chg = chg_q;
   assign err = err_q;

endmodule

// File: rtl/rotary_pos_tracker.sv
// Two-axis rotary encoder front end: X encoder drives posx, Y encoder drives posy,
// with shared moved/qerr pulses.
module rotary_pos_tracker
   import rotary_pos_tracker_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned DEB_CYCLES = 50000,
   parameter int unsigned STEP       = DEF_STEP,
   parameter int unsigned X_MIN      = 0,
   parameter int unsigned X_MAX      = 620,
   parameter int unsigned Y_MIN      = 0,
   parameter int unsigned Y_MAX      = 460
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] reset_value,
   input  logic             left_a,
   input  logic             left_b,
   input  logic             right_a,
   input  logic             right_b,
   output logic [WIDTH-1:0] posx,
   output logic [WIDTH-1:0] posy,
   output logic             moved,
   output logic             qerr
);

   logic chg_x, chg_y, err_x, err_y;

   quad_axis #(
      .WIDTH      (WIDTH),
      .DEB_CYCLES (DEB_CYCLES),
      .STEP       (STEP),
      .MIN        (X_MIN),
      .MAX        (X_MAX)
   ) u_axis_x (
      .clk         (clk),
      .reset       (reset),
      .reset_value (reset_value),
      .a           (left_a),
      .b           (left_b),
      .pos         (posx),
      .chg         (chg_x),
      .err         (err_x)
   );

   quad_axis #(
      .WIDTH      (WIDTH),
      .DEB_CYCLES (DEB_CYCLES),
      .STEP       (STEP),
      .MIN        (Y_MIN),
      .MAX        (Y_MAX)
   ) u_axis_y (
      .clk         (clk),
      .reset       (reset),
      .reset_value (reset_value),
      .a           (right_a),
      .b           (right_b),
      .pos         (posy),
      .chg         (chg_y),
      .err         (err_y)
   );

   assign moved = chg_x | chg_y;
   assign qerr  = err_x | err_y;

endmodule

// File: tb/tb_rotary_pos_tracker.sv
// Directed table-driven bench for rotary_pos_tracker with DEB_CYCLES=4, STEP=4.
module tb_rotary_pos_tracker;

   localparam int WIDTH = 16;
   localparam int HOLD  = 10;

   typedef enum int {OpStep, OpReset, OpGlitch} op_e;

   typedef struct {
      op_e        op;
      int         rst_cyc;
      int         rv;
      logic [1:0] lab;
      logic [1:0] rab;
      int         ex;
      int         ey;
      int         emv;
      int         eqe;
      int         elx;
      int         ely;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] reset_value = 16'd100;
   logic             left_a = 1'b0, left_b = 1'b0, right_a = 1'b0, right_b = 1'b0;
   logic [WIDTH-1:0] posx, posy;
   logic             moved, qerr;

   int n_cmp = 0;
   int n_fail = 0;
   vec_t vecs[$];

   rotary_pos_tracker #(
      .WIDTH      (WIDTH),
      .DEB_CYCLES (4),
      .STEP       (4),
      .X_MIN      (0),
      .X_MAX      (620),
      .Y_MIN      (0),
      .Y_MAX      (460)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .reset_value (reset_value),
      .left_a      (left_a),
      .left_b      (left_b),
      .right_a     (right_a),
      .right_b     (right_b),
      .posx        (posx),
      .posy        (posy),
      .moved       (moved),
      .qerr        (qerr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input op_e op, input int rst_cyc, input int rv, input logic [1:0] lab,
                      input logic [1:0] rab, input int ex, input int ey, input int emv,
                      input int eqe, input int elx, input int ely);
      vec_t v;
      v.op = op; v.rst_cyc = rst_cyc; v.rv = rv; v.lab = lab; v.rab = rab;
      v.ex = ex; v.ey = ey; v.emv = emv; v.eqe = eqe; v.elx = elx; v.ely = ely;
      vecs.push_back(v);
   endtask

   task automatic step(input logic [1:0] lab, input logic [1:0] rab, input int ex,
                       input int ey, input int emv, input int eqe, input int elx, input int ely);
      add(OpStep, 0, 0, lab, rab, ex, ey, emv, eqe, elx, ely);
   endtask

   task automatic rst(input int cyc, input int rv, input logic [1:0] lab, input logic [1:0] rab,
                      input int ex, input int ey);
      add(OpReset, cyc, rv, lab, rab, ex, ey, 0, 0, 0, 0);
   endtask

   initial begin
      int mv_cnt, qe_cnt, latx, laty;
      logic [WIDTH-1:0] px0, py0;
      string tag;

      // 1: reset
      rst(3, 100, 2'b00, 2'b00, 100, 100);
      // 2: X forward detent; move lands 8 cycles after the final pin edge
      step(2'b01, 2'b00, 100, 100, 0, 0, 0, 0);
      step(2'b11, 2'b00, 100, 100, 0, 0, 0, 0);
      step(2'b10, 2'b00, 100, 100, 0, 0, 0, 0);
      step(2'b00, 2'b00, 104, 100, 1, 0, 8, 0);
      // 3: Y reverse detent, then three reverse transitions only
      step(2'b00, 2'b10, 104, 100, 0, 0, 0, 0);
      step(2'b00, 2'b11, 104, 100, 0, 0, 0, 0);
      step(2'b00, 2'b01, 104, 100, 0, 0, 0, 0);
      step(2'b00, 2'b00, 104,  96, 1, 0, 0, 8);
      step(2'b00, 2'b10, 104,  96, 0, 0, 0, 0);
      step(2'b00, 2'b11, 104,  96, 0, 0, 0, 0);
      step(2'b00, 2'b01, 104,  96, 0, 0, 0, 0);
      // 5: glitch on left_a, then illegal X jumps out and back
      add(OpGlitch, 0, 0, 2'b00, 2'b01, 104, 96, 0, 0, 0, 0);
      step(2'b11, 2'b01, 104,  96, 0, 1, 0, 0);
      step(2'b00, 2'b01, 104,  96, 0, 1, 0, 0);
      // fourth reverse Y transition completes a detent
      step(2'b00, 2'b00, 104,  92, 1, 0, 0, 8);
      // 4: upper clamp on X, Y reset value clamped to 460
      rst(2, 618, 2'b00, 2'b00, 618, 460);
      step(2'b01, 2'b00, 618, 460, 0, 0, 0, 0);
      step(2'b11, 2'b00, 618, 460, 0, 0, 0, 0);
      step(2'b10, 2'b00, 618, 460, 0, 0, 0, 0);
      step(2'b00, 2'b00, 620, 460, 1, 0, 8, 0);
      step(2'b01, 2'b00, 620, 460, 0, 0, 0, 0);
      step(2'b11, 2'b00, 620, 460, 0, 0, 0, 0);
      step(2'b10, 2'b00, 620, 460, 0, 0, 0, 0);
      step(2'b00, 2'b00, 620, 460, 0, 0, 0, 0);
      // lower clamp on Y
      rst(2, 2, 2'b00, 2'b00, 2, 2);
      step(2'b00, 2'b10, 2, 2, 0, 0, 0, 0);
      step(2'b00, 2'b11, 2, 2, 0, 0, 0, 0);
      step(2'b00, 2'b01, 2, 2, 0, 0, 0, 0);
      step(2'b00, 2'b00, 2, 0, 1, 0, 0, 8);
      // 6: partial detent discarded by reset; pins sit at 11 so re-sync is a jump
      rst(3, 100, 2'b00, 2'b00, 100, 100);
      step(2'b01, 2'b00, 100, 100, 0, 0, 0, 0);
      step(2'b11, 2'b00, 100, 100, 0, 0, 0, 0);
      rst(1, 100, 2'b11, 2'b00, 100, 100);
      step(2'b11, 2'b00, 100, 100, 0, 1, 0, 0);
      step(2'b10, 2'b00, 100, 100, 0, 0, 0, 0);
      step(2'b00, 2'b00, 100, 100, 0, 0, 0, 0);
      step(2'b01, 2'b00, 100, 100, 0, 0, 0, 0);
      step(2'b11, 2'b00, 104, 100, 1, 0, 8, 0);
      // simultaneous forward detents on both axes
      step(2'b10, 2'b01, 104, 100, 0, 0, 0, 0);
      step(2'b00, 2'b11, 104, 100, 0, 0, 0, 0);
      step(2'b01, 2'b10, 104, 100, 0, 0, 0, 0);
      step(2'b11, 2'b00, 108, 104, 1, 0, 8, 8);

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         tag = $sformatf("v%0d", i);
         @(posedge clk);
         #1;
         {left_a, left_b}   = v.lab;
         {right_a, right_b} = v.rab;
         if (v.op == OpReset) begin
            reset       = 1'b1;
            reset_value = WIDTH'(v.rv);
            repeat (v.rst_cyc) @(posedge clk);
            #1;
            reset = 1'b0;
            chk({tag, " rst posx"}, int'(posx), v.ex);
            chk({tag, " rst posy"}, int'(posy), v.ey);
            chk({tag, " rst moved"}, int'(moved), 0);
            chk({tag, " rst qerr"}, int'(qerr), 0);
         end else begin
            if (v.op == OpGlitch) begin
               left_a = 1'b1;
               repeat (2) @(posedge clk);
               #1;
               left_a = v.lab[1];
            end
            px0 = posx;
            py0 = posy;
            mv_cnt = 0; qe_cnt = 0; latx = 0; laty = 0;
            for (int c = 1; c <= HOLD; c++) begin
               @(posedge clk);
               #1;
               if (moved) mv_cnt++;
               if (qerr) qe_cnt++;
               if (latx == 0 && posx != px0) latx = c;
               if (laty == 0 && posy != py0) laty = c;
            end
            chk({tag, " posx"}, int'(posx), v.ex);
            chk({tag, " posy"}, int'(posy), v.ey);
            chk({tag, " moved pulses"}, mv_cnt, v.emv);
            chk({tag, " qerr pulses"}, qe_cnt, v.eqe);
            chk({tag, " posx latency"}, latx, v.elx);
            chk({tag, " posy latency"}, laty, v.ely);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
